// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data memory responder
package dmem_responder_pkg;

    localparam int REQ_ADDR_W = 9;
    localparam int REQ_DATA_W = 32;

    // RV32I load/store size and sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic                  re;
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// rtl/dmem_responder_lane_align.sv - byte-lane steering, load extension and access legality
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] store_word,
    output logic [31:0] load_word,
    output logic        access_err
);

    logic [31:0] shifted;

    // Decode size, steer store bytes into their lanes and extend the addressed load bytes
    always_comb begin
        byte_mask  = 4'b0000;
        store_word = 32'h0;
        load_word  = 32'h0;
        access_err = 1'b0;
        shifted    = ram_word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B: begin
                byte_mask  = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
                load_word  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                access_err = addr_lo[0];
                byte_mask  = 4'b0011 << addr_lo;
                store_word = {2{store_data[15:0]}};
                load_word  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                access_err = |addr_lo;
                byte_mask  = 4'b1111;
                store_word = store_data;
                load_word  = ram_word;
            end
            F3_BU: begin
                // unsigned variants exist only for loads
                access_err = is_store;
                load_word  = {24'h0, shifted[7:0]};
            end
            F3_HU: begin
                access_err = is_store | addr_lo[0];
                load_word  = {16'h0, shifted[15:0]};
            end
            default: access_err = 1'b1;
        endcase
        if (access_err) begin
            byte_mask = 4'b0000;
            load_word = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder with configurable wait states
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_re,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int         DEPTH     = 1 << (DM_ADDRESS - 2);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                state;
    logic [3:0]            wait_cnt;
    dmem_req_t             lat;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DM_ADDRESS-3:0] word_idx;
    logic [DATA_W-1:0]     ram_word;
    logic [DATA_W-1:0]     store_word;
    logic [DATA_W-1:0]     load_word;
    logic [3:0]            byte_mask;
    logic                  align_err;
    logic                  access_err;
    logic                  accept;

    assign word_idx   = lat.addr[DM_ADDRESS-1:2];
    assign ram_word   = mem[word_idx];
    assign access_err = (lat.re & lat.we) | align_err;
    assign accept     = (state == ST_IDLE) & req_ready & req_valid & (req_re | req_we);

    dmem_lane_align u_align (
        .funct3     (lat.funct3),
        .is_store   (lat.we),
        .addr_lo    (lat.addr[1:0]),
        .store_data (lat.wdata),
        .ram_word   (ram_word),
        .byte_mask  (byte_mask),
        .store_word (store_word),
        .load_word  (load_word),
        .access_err (align_err)
    );

    // Request sequencing: accept in IDLE, count wait states, answer from RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= 4'h0;
            lat       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        lat.re     <= req_re;
                        lat.we     <= req_we;
                        lat.addr   <= req_addr;
                        lat.wdata  <= req_wdata;
                        lat.funct3 <= req_funct3;
                        req_ready  <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'h0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end
                end
                ST_RESP: begin
                    // load data is sampled from the array as it stands in this cycle
                    rsp_valid <= 1'b1;
                    rsp_err   <= access_err;
                    rsp_rdata <= (lat.re && !access_err) ? load_word : '0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Store commit on the edge leaving RESP; a reset before that edge drops the write
    always_ff @(posedge clk) begin
        if (state == ST_RESP && lat.we && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        reset_n;
    logic        req_valid, req_re, req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_re, z_req_we;
    logic [8:0]  z_req_addr;
    logic [31:0] z_req_wdata;
    logic [2:0]  z_req_funct3;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [0:511];

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_re(req_re), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_re(z_req_re), .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_funct3(z_req_funct3), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference: size/sign from funct3, alignment by modulo, little-endian bytes
    function automatic void model_access(input logic re, input logic we, input logic [8:0] a,
                                         input logic [31:0] wd, input logic [2:0] f3,
                                         output logic [31:0] rd, output logic e);
        int size;
        bit sgn;
        int val;
        size = 1; sgn = 0; val = 0; e = 0; rd = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; e = we; end
            3'd5: begin size = 2; sgn = 0; e = we; end
            default: e = 1;
        endcase
        if (re && we) e = 1;
        if ((int'(a) % size) != 0) e = 1;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < size; i++) mb[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) val = val + (int'(mb[int'(a) + i]) << (8 * i));
                if (sgn && size == 1 && val >= 128)   val = val - 256;
                if (sgn && size == 2 && val >= 32768) val = val - 65536;
                rd = 32'(val);
            end
        end
    endfunction

    task automatic drive(input bit z, input logic v, input logic re, input logic we,
                         input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3);
        if (z) begin
            z_req_valid = v; z_req_re = re; z_req_we = we;
            z_req_addr = a; z_req_wdata = wd; z_req_funct3 = f3;
        end else begin
            req_valid = v; req_re = re; req_we = we;
            req_addr = a; req_wdata = wd; req_funct3 = f3;
        end
    endtask

    // One transaction on the WAIT_STATES=2 instance; response checked against the model
    task automatic do_req(input logic re, input logic we, input logic [8:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input string tag,
                          output int lat, output int rdy_low, output logic [31:0] obs);
        logic [31:0] er;
        logic        ee;
        int          n;
        model_access(re, we, a, wd, f3, er, ee);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        drive(0, 1'b1, re, we, a, wd, f3);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
        lat = 1; rdy_low = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (req_ready === 1'b0) rdy_low++;
            @(negedge clk);
            lat++;
        end
        obs = rsp_rdata;
        check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, "_rdata"}, rsp_rdata, er);
        check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, ee});
        @(negedge clk);
        check({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    // Hold req_valid high with three queued stores and record accept/response cycles
    task automatic run_burst(input bit z, input int ws, input string tag);
        int acc [3];
        int rsp [3];
        int na, nr;
        logic rdy, rv;
        logic [31:0] er;
        logic        ee;
        logic [8:0]  ba;
        ba = 9'h040; na = 0; nr = 0;
        drive(z, 1'b1, 1'b0, 1'b1, ba, 32'hA0A0_0000, 3'b010);
        for (int cyc = 0; cyc < 80 && (na < 3 || nr < 3); cyc++) begin
            rdy = z ? z_req_ready : req_ready;
            @(posedge clk);
            @(negedge clk);
            rv = z ? z_rsp_valid : rsp_valid;
            if (rv === 1'b1 && nr < 3) begin rsp[nr] = cyc; nr++; end
            if (rdy === 1'b1 && na < 3) begin
                if (!z) model_access(1'b0, 1'b1, ba + 9'(4 * na), 32'hA0A0_0000 + 32'(na), 3'b010, er, ee);
                acc[na] = cyc;
                na++;
                if (na < 3) drive(z, 1'b1, 1'b0, 1'b1, ba + 9'(4 * na), 32'hA0A0_0000 + 32'(na), 3'b010);
                else        drive(z, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
            end
        end
        check({tag, "_accepts"}, 32'(na), 32'd3);
        check({tag, "_responses"}, 32'(nr), 32'd3);
        for (int i = 1; i < 3; i++) check({tag, "_spacing"}, 32'(acc[i] - acc[i-1]), 32'(ws + 2));
        for (int i = 0; i < 3; i++) check({tag, "_latency"}, 32'(rsp[i] - acc[i]), 32'(ws + 1));
    endtask

    initial begin : main
        int lat, rl;
        logic [31:0] obs;
        int seen;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'h0, rsp_err}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        for (int w = 0; w < 32; w++)
            do_req(1'b0, 1'b1, 9'(4 * w), $urandom, 3'b010, "fill", lat, rl, obs);

        do_req(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, "sw", lat, rl, obs);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "lw", lat, rl, obs);
        check("lw_const", obs, 32'hDEADBEEF);
        check("lw_latency", 32'(lat), 32'd4);
        check("lw_ready_low", 32'(rl), 32'd3);

        do_req(1'b0, 1'b1, 9'h011, 32'h0000_0080, 3'b000, "sb", lat, rl, obs);
        do_req(1'b1, 1'b0, 9'h011, 32'h0, 3'b000, "lb", lat, rl, obs);
        check("lb_const", obs, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 9'h011, 32'h0, 3'b100, "lbu", lat, rl, obs);
        check("lbu_const", obs, 32'h00000080);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "lw_sb", lat, rl, obs);
        check("lw_sb_const", obs, 32'hDEAD80EF);

        do_req(1'b0, 1'b1, 9'h012, 32'h0000_8001, 3'b001, "sh", lat, rl, obs);
        do_req(1'b1, 1'b0, 9'h012, 32'h0, 3'b001, "lh", lat, rl, obs);
        check("lh_const", obs, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 9'h012, 32'h0, 3'b101, "lhu", lat, rl, obs);
        check("lhu_const", obs, 32'h00008001);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "lw_sh", lat, rl, obs);
        check("lw_sh_const", obs, 32'h800180EF);

        do_req(1'b1, 1'b0, 9'h013, 32'h0, 3'b010, "lw_mis", lat, rl, obs);
        do_req(1'b0, 1'b1, 9'h011, 32'h0000_FFFF, 3'b001, "sh_mis", lat, rl, obs);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b011, "ld_f3", lat, rl, obs);
        do_req(1'b1, 1'b1, 9'h010, 32'h1111_1111, 3'b010, "re_we", lat, rl, obs);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "lw_after", lat, rl, obs);
        check("lw_after_const", obs, 32'h800180EF);

        drive(0, 1'b1, 1'b0, 1'b0, 9'h010, 32'h0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noen_ready", {31'h0, req_ready}, 32'h1);
            check("noen_valid", {31'h0, rsp_valid}, 32'h0);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);

        run_burst(0, 2, "burst_ws2");
        run_burst(1, 0, "burst_ws0");
        for (int i = 0; i < 3; i++)
            do_req(1'b1, 1'b0, 9'(9'h040 + 4 * i), 32'h0, 3'b010, "burst_rd", lat, rl, obs);

        do_req(1'b0, 1'b1, 9'h020, 32'h0, 3'b010, "sw_zero", lat, rl, obs);
        drive(0, 1'b1, 1'b0, 1'b1, 9'h020, 32'h12345678, 3'b010);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'h0);
        reset_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("abort_ready2", {31'h0, req_ready}, 32'h0);
        check("abort_valid", {31'h0, rsp_valid}, 32'h0);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        do_req(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, "lw_abort", lat, rl, obs);
        check("lw_abort_const", obs, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int r;
            logic re, we;
            r  = $urandom_range(0, 9);
            re = (r < 5) || (r == 9);
            we = (r >= 5);
            do_req(re, we, 9'($urandom_range(0, 127)), $urandom, 3'($urandom_range(0, 7)),
                   "rand", lat, rl, obs);
            check("rand_latency", 32'(lat), 32'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
